// File: rtl/rca_arb_if.sv
// Bundle of request, shared-adder and response signals for rca_arb.
// The slave modport is the arbiter's view; master is the surrounding system.
interface rca_arb_if #(
    parameter int unsigned N = 4
);
    logic [1:0]   req_valid_i;
    logic [1:0]   req_ready_o;
    logic [N-1:0] a0_i;
    logic [N-1:0] b0_i;
    logic         c0_i;
    logic [N-1:0] a1_i;
    logic [N-1:0] b1_i;
    logic         c1_i;
    logic [N-1:0] add_a_o;
    logic [N-1:0] add_b_o;
    logic         add_c_o;
    logic [N-1:0] add_s_i;
    logic         add_c_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic         rsp_id_o;
    logic [N-1:0] rsp_s_o;
    logic         rsp_c_o;
    logic         busy_o;

    modport slave (
        input  req_valid_i, a0_i, b0_i, c0_i, a1_i, b1_i, c1_i,
        input  add_s_i, add_c_i, rsp_ready_i,
        output req_ready_o, add_a_o, add_b_o, add_c_o,
        output rsp_valid_o, rsp_id_o, rsp_s_o, rsp_c_o, busy_o
    );

    modport master (
        output req_valid_i, a0_i, b0_i, c0_i, a1_i, b1_i, c1_i,
        output add_s_i, add_c_i, rsp_ready_i,
        input  req_ready_o, add_a_o, add_b_o, add_c_o,
        input  rsp_valid_o, rsp_id_o, rsp_s_o, rsp_c_o, busy_o
    );
endinterface

// File: rtl/rca_arb.sv
// Two-requester round-robin arbiter in front of a shared registered adder.
// One operation in flight: IDLE -> ISSUE -> CAPT -> RESP -> IDLE.
module rca_arb #(
    parameter int unsigned N = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    rca_arb_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_e;

    state_e       state_q, state_d;
    logic         rr_q, rr_d;
    logic         owner_q, owner_d;
    logic [N-1:0] add_a_q, add_a_d;
    logic [N-1:0] add_b_q, add_b_d;
    logic         add_c_q, add_c_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_id_q, rsp_id_d;
    logic [N-1:0] rsp_s_q, rsp_s_d;
    logic         rsp_c_q, rsp_c_d;
    logic [1:0]   ready;
    logic         gnt_id;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_c_d     = add_c_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_s_d     = rsp_s_q;
        rsp_c_d     = rsp_c_q;
        ready       = '0;
        gnt_id      = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid_i) begin
                    // Single requester wins outright; contention goes to the pointer.
                    if (bus.req_valid_i == 2'b11) gnt_id = rr_q;
                    else                          gnt_id = bus.req_valid_i[1];
                    ready   = gnt_id ? 2'b10 : 2'b01;
                    add_a_d = gnt_id ? bus.a1_i : bus.a0_i;
                    add_b_d = gnt_id ? bus.b1_i : bus.b0_i;
                    add_c_d = gnt_id ? bus.c1_i : bus.c0_i;
                    owner_d = gnt_id;
                    rr_d    = ~gnt_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                rsp_s_d     = bus.add_s_i;
                rsp_c_d     = bus.add_c_i;
                rsp_id_d    = owner_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            owner_q     <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_c_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_s_q     <= '0;
            rsp_c_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_c_q     <= add_c_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_s_q     <= rsp_s_d;
            rsp_c_q     <= rsp_c_d;
        end
    end

    // The grant is combinational, so it is gated here to stay low while reset is held.
    assign bus.req_ready_o = rst_ni ? ready : 2'b00;
    assign bus.add_a_o     = add_a_q;
    assign bus.add_b_o     = add_b_q;
    assign bus.add_c_o     = add_c_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_id_o    = rsp_id_q;
    assign bus.rsp_s_o     = rsp_s_q;
    assign bus.rsp_c_o     = rsp_c_q;
    assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_rca_arb.sv
// Directed and scoreboarded checks of rca_arb with a behavioural registered adder.
module tb_rca_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    rca_arb_if #(.N(4)) bus ();
    rca_arb #(.N(4)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Shared adder: result registered one edge after the operands are sampled.
    logic [4:0] add_full;
    assign add_full = {1'b0, bus.add_a_o} + {1'b0, bus.add_b_o} + {4'b0, bus.add_c_o};
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.add_s_i <= 4'h0;
            bus.add_c_i <= 1'b0;
        end else begin
            bus.add_s_i <= add_full[3:0];
            bus.add_c_i <= add_full[4];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] all_outs();
        return {bus.req_ready_o, bus.add_a_o, bus.add_b_o, bus.add_c_o, bus.rsp_valid_o,
                bus.rsp_id_o, bus.rsp_s_o, bus.rsp_c_o, bus.busy_o};
    endfunction

    // Called at a falling edge while the DUT is idle; runs one full operation with rsp_ready high.
    task automatic op(input logic [1:0] v, input logic eid, input logic [8:0] eadd,
                      input logic [4:0] esum, input string tag);
        bus.req_valid_i = v;
        bus.rsp_ready_i = 1'b1;
        #1;
        chk({tag, "_rdy"}, bus.req_ready_o, eid ? 2'b10 : 2'b01);
        @(negedge clk);
        chk({tag, "_issue"}, {bus.busy_o, bus.req_ready_o, bus.rsp_valid_o}, 4'b1000);
        chk({tag, "_add"}, {bus.add_a_o, bus.add_b_o, bus.add_c_o}, eadd);
        @(negedge clk);
        chk({tag, "_capt"}, {bus.busy_o, bus.req_ready_o, bus.rsp_valid_o}, 4'b1000);
        @(negedge clk);
        chk({tag, "_rsp"}, {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_c_o, bus.rsp_s_o}, {1'b1, eid, esum});
        @(negedge clk);
        chk({tag, "_done"}, {bus.busy_o, bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_c_o, bus.rsp_s_o},
            {2'b00, eid, esum});
        bus.req_valid_i = 2'b00;
    endtask

    logic [5:0] q[$];
    logic [5:0] exp_e;
    logic [4:0] s5;
    logic       rr_m;
    logic       gid;
    logic [1:0] vv;
    int unsigned cyc;
    int accepted;
    int responded;

    initial begin
        bus.req_valid_i = 2'b11;
        bus.rsp_ready_i = 1'b0;
        bus.a0_i = 4'h3; bus.b0_i = 4'h5; bus.c0_i = 1'b1;
        bus.a1_i = 4'hF; bus.b1_i = 4'hF; bus.c1_i = 1'b1;

        // Reset holds everything low even with requests pending.
        repeat (2) @(negedge clk);
        chk("reset_outs", all_outs(), 19'h0);
        bus.req_valid_i = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        op(2'b01, 1'b0, {4'h3, 4'h5, 1'b1}, 5'h09, "basic");
        op(2'b10, 1'b1, {4'hF, 4'hF, 1'b1}, 5'h1F, "ovf");

        bus.a0_i = 4'h1; bus.b0_i = 4'h2; bus.c0_i = 1'b0;
        bus.a1_i = 4'h7; bus.b1_i = 4'h8; bus.c1_i = 1'b1;
        op(2'b11, 1'b0, {4'h1, 4'h2, 1'b0}, 5'h03, "rr0");
        op(2'b11, 1'b1, {4'h7, 4'h8, 1'b1}, 5'h10, "rr1");
        op(2'b11, 1'b0, {4'h1, 4'h2, 1'b0}, 5'h03, "rr2");
        op(2'b11, 1'b1, {4'h7, 4'h8, 1'b1}, 5'h10, "rr3");

        // Backpressure: response held while rsp_ready stays low, no grants meanwhile.
        bus.a0_i = 4'h6; bus.b0_i = 4'h6; bus.c0_i = 1'b0;
        bus.req_valid_i = 2'b11;
        bus.rsp_ready_i = 1'b0;
        #1;
        chk("bp_rdy", bus.req_ready_o, 2'b01);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.a0_i = 4'(i);
            #1;
            chk("bp_hold", {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_c_o, bus.rsp_s_o, bus.busy_o,
                            bus.req_ready_o}, {1'b1, 1'b0, 5'h0C, 1'b1, 2'b00});
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b1;
        bus.req_valid_i = 2'b00;
        @(negedge clk);
        chk("bp_release", {bus.busy_o, bus.rsp_valid_o}, 2'b00);

        // Reset while requester 1's operation is in CAPT.
        bus.req_valid_i = 2'b11;
        #1;
        chk("abort_rdy", bus.req_ready_o, 2'b10);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", all_outs(), 19'h0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_hold", all_outs(), 19'h0);
        rst_n = 1'b1;
        bus.a0_i = 4'h4; bus.b0_i = 4'h9; bus.c0_i = 1'b1;
        op(2'b11, 1'b0, {4'h4, 4'h9, 1'b1}, 5'h0E, "post_rst");

        // Random traffic against a grant-order scoreboard.
        rr_m = 1'b1;
        cyc = 0;
        accepted = 0;
        responded = 0;
        while (responded < 200 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            bus.req_valid_i = (accepted < 200) ? 2'($urandom_range(0, 3)) : 2'b00;
            bus.a0_i = 4'($urandom); bus.b0_i = 4'($urandom); bus.c0_i = 1'($urandom);
            bus.a1_i = 4'($urandom); bus.b1_i = 4'($urandom); bus.c1_i = 1'($urandom);
            bus.rsp_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (bus.req_ready_o != 2'b00) begin
                vv = bus.req_valid_i;
                gid = bus.req_ready_o[1];
                chk("rnd_onehot", (bus.req_ready_o == 2'b01 || bus.req_ready_o == 2'b10), 1);
                chk("rnd_gnt", gid, (vv == 2'b11) ? rr_m : vv[1]);
                rr_m = ~gid;
                s5 = gid ? ({1'b0, bus.a1_i} + {1'b0, bus.b1_i} + {4'b0, bus.c1_i})
                         : ({1'b0, bus.a0_i} + {1'b0, bus.b0_i} + {4'b0, bus.c0_i});
                q.push_back({gid, s5});
                accepted++;
            end
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                chk("rnd_pending", (q.size() > 0), 1);
                if (q.size() > 0) begin
                    exp_e = q.pop_front();
                    chk("rnd_rsp", {bus.rsp_id_o, bus.rsp_c_o, bus.rsp_s_o}, exp_e);
                end
                responded++;
            end
        end
        chk("rnd_count", responded, 200);
        chk("rnd_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
